keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Scans the on-board 4x4 key matrix: drives btn_key_col and samples btn_key_row.
//  Debounces the matrix and emits one key-code event per new press over a valid/ready
//  interface. Sits between the board pins and the SoC GPIO/interrupt logic.
// PARAMETERS
//  SCAN_DIV        50000  clk cycles each column is driven (dwell); >=4
//  DEBOUNCE_SCANS  4      identical consecutive full sweeps required before the stable map updates; >=1
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  btn_key_col  out  4   column drive, active-low, exactly one bit low at a time
//  btn_key_row  in   4   row sense, active-low (pulled up), asynchronous to clk
//  key_state    out  16  debounced map; bit k=1 -> key k held, k = row*4 + col
//  key_valid    out  1   event holding register full
//  key_ready    in   1   consumer accepts event when key_valid & key_ready
//  key_code     out  4   code of the newly pressed key (row*4 + col)
//  key_drop     out  1   1-cycle pulse: press lost because its pending bit was already set
// BEHAVIOUR
//  Reset (async): btn_key_col=4'b1110, key_state=0, key_valid=0, key_code=0, key_drop=0.
//   Also clears the dwell counter, column index, snapshot, debounce counter and pending mask.
//  Row input: 2-FF synchronizer, reset to 4'b1111; pressed = ~sync_row.
//  Dwell counter: counts 0..SCAN_DIV-1 and wraps.
//   At count SCAN_DIV-1, the 4 pressed bits are written into snapshot bits {r*4+col}.
//   On that same cycle the column index advances 0->1->2->3->0.
//   btn_key_col = ~(1<<col) is registered, so it changes on the cycle after the wrap.
//  Sweep ends on the sample at col 3, i.e. every 4*SCAN_DIV cycles.
//   On sweep end:
//   - If snapshot == last_sweep, deb_cnt saturates-increments; otherwise deb_cnt=0.
//   - last_sweep <= snapshot.
//   - When the comparison matches and deb_cnt+1 >= DEBOUNCE_SCANS-1, or DEBOUNCE_SCANS==1:
//     key_state <= snapshot the following cycle.
//  New presses: rise = snapshot & ~key_state, computed on the key_state update cycle.
//   pending <= pending | rise.
//   key_drop pulses if (pending & rise) != 0.
//   Releases clear key_state bits only; they generate no event.
//  Event register (1 entry):
//   - Loads when (~key_valid | key_ready) and pending != 0.
//   - key_code <= lowest set index of pending; that bit clears; key_valid <= 1.
//   - If key_valid & key_ready and pending == 0: key_valid <= 0.
//   - key_code holds stable while key_valid & ~key_ready.
//   - Back-to-back accepts sustain one event per cycle.
//  Simultaneous rise and drain on one cycle:
//   - Drain uses the pre-update pending.
//   - A rise bit equal to the bit being drained sets it again; no key_drop.
//  Latency: sweep-end cycle N with a qualifying match -> key_state at N+1.
//   With an empty register, key_valid at N+2.
//  Ghosting from 3+ keys is not resolved; the raw matrix is reported.
//  Counter widths: dwell $clog2(SCAN_DIV); deb_cnt $clog2(DEBOUNCE_SCANS+1), saturating.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=2)
//  The bench models the matrix: row r is low iff the key (r,c) is held and col c is low.
//  1 Reset, idle -> btn_key_col cycles 1110,1101,1011,0111, each 4 clk.
//    key_valid=0 and key_state=0 throughout.
//  2 Hold key (r1,c2) -> key_state=16'h0040 after the 2nd matching sweep.
//    key_valid=1 with key_code=6 two clk after that sweep end.
//    Accept with ready=1 -> key_valid=0. No repeat while held.
//  3 Toggle key 5 every sweep -> key_state stays 0 and no event.
//    Hold it steadily -> exactly one event, code 5.
//  4 Press keys 3 and 12 together with key_ready=0 -> key_valid=1, code=3, held stable.
//    Raise ready -> next cycle code=12. Then key_valid=0.
//  5 Release key 12 -> bit12 clears with no event.
//    Re-press before key 12 is drained -> key_drop pulse.
//  6 Assert rst while pending!=0 and key_valid=1 -> all outputs return to reset values immediately.
//    No event appears after rst is released.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 key-matrix scanner: column drive, 2-FF row sync, sweep debounce, 1-entry press-event register.
// key_state lags a qualifying sweep end by 1 clk, key_valid by 2; key_code holds while key_ready is low.
module keypad_scan #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [3:0]  btn_key_col,
   input  logic [3:0]  btn_key_row,
   output logic [15:0] key_state,
   output logic        key_valid,
   input  logic        key_ready,
   output logic [3:0]  key_code,
   output logic        key_drop
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

   logic [3:0]    row_s1, row_s2, pressed;
   logic [CW-1:0] dwell;
   logic [1:0]    col;
   logic [15:0]   snapshot, snap_full, last_sweep;
   logic [15:0]   pending, pending_n, rise, drain;
   logic [DW-1:0] deb_cnt;
   logic [3:0]    drain_idx;
   logic          wrap, sweep_end, match, adopt, load;

   assign pressed   = ~row_s2;
   assign wrap      = (dwell == CW'(SCAN_DIV - 1));
   assign sweep_end = wrap && (col == 2'd3);
   assign match     = (snap_full == last_sweep);
   assign adopt     = sweep_end && ((DEBOUNCE_SCANS == 1) ||
                      (match && (int'(deb_cnt) + 1 >= DEBOUNCE_SCANS - 1)));
   assign rise      = adopt ? (snap_full & ~key_state) : '0;
   assign load      = (!key_valid || key_ready) && (pending != '0);

   // Snapshot as it will look after this cycle's column sample, so the sweep-end compare sees col 3.
   always_comb begin
      snap_full = snapshot;
      if (wrap) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               if (col == 2'(c)) snap_full[r*4 + c] = pressed[r];
            end
         end
      end
   end

   always_comb begin
      drain_idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (pending[i]) drain_idx = 4'(i);
      end
      drain     = load ? (16'h0001 << drain_idx) : '0;
      pending_n = (pending & ~drain) | rise;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1      <= 4'b1111;
         row_s2      <= 4'b1111;
         dwell       <= '0;
         col         <= '0;
         btn_key_col <= 4'b1110;
         snapshot    <= '0;
      end else begin
         row_s1 <= btn_key_row;
         row_s2 <= row_s1;
         if (wrap) begin
            dwell       <= '0;
            col         <= col + 2'd1;
            btn_key_col <= ~(4'b0001 << (col + 2'd1));
            snapshot    <= snap_full;
         end else begin
            dwell <= dwell + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_sweep <= '0;
         deb_cnt    <= '0;
         key_state  <= '0;
      end else begin
         if (sweep_end) begin
            last_sweep <= snap_full;
            if (!match)
               deb_cnt <= '0;
            else if (deb_cnt != DW'(DEBOUNCE_SCANS))
               deb_cnt <= deb_cnt + DW'(1);
         end
         if (adopt) key_state <= snap_full;
      end
   end

   // A rise on the bit being drained this cycle re-arms it instead of counting as lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
         key_drop  <= 1'b0;
      end else begin
         pending  <= pending_n;
         key_drop <= |(pending & ~drain & rise);
         if (load) begin
            key_valid <= 1'b1;
            key_code  <= drain_idx;
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: matrix model drives rows, sweep-level reference model feeds an event scoreboard.
module tb_keypad_scan;
   localparam int SD = 4;
   localparam int DS = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  btn_key_col, btn_key_row, key_code;
   logic [15:0] key_state, held;
   logic        key_valid, key_ready, key_drop;

   int n_chk = 0, n_pass = 0;
   int exp_q[$];
   int drops_exp = 0, drops_seen = 0;
   logic [15:0] m_last, m_state;
   int m_run;

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clk(clk), .rst(rst), .btn_key_col(btn_key_col), .btn_key_row(btn_key_row),
      .key_state(key_state), .key_valid(key_valid), .key_ready(key_ready),
      .key_code(key_code), .key_drop(key_drop)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] matrix(input logic [15:0] h, input logic [3:0] cols);
      logic [3:0] r;
      r = 4'hF;
      for (int rr = 0; rr < 4; rr++)
         for (int c = 0; c < 4; c++)
            if (h[rr*4 + c] && !cols[c]) r[rr] = 1'b0;
      return r;
   endfunction
   assign btn_key_row = matrix(held, btn_key_col);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic model_reset();
      m_last = '0; m_state = '0; m_run = 1;
      exp_q.delete();
   endtask

   // Key map adopted once DS identical sweeps in a row have been seen; new presses queue in ascending order.
   task automatic model_sweep(input logic [15:0] map);
      bit waiting;
      if (map == m_last) m_run++; else m_run = 1;
      m_last = map;
      if (m_run >= DS) begin
         for (int b = 0; b < 16; b++) begin
            if (map[b] && !m_state[b]) begin
               waiting = 0;
               for (int i = 1; i < exp_q.size(); i++) if (exp_q[i] == b) waiting = 1;
               if (waiting) drops_exp++; else exp_q.push_back(b);
            end
         end
         m_state = map;
      end
   endtask

   task automatic end_sweep(input int used);
      repeat (16 - used) @(negedge clk);
      model_sweep(held);
      check("key_state", key_state, m_state);
   endtask

   task automatic sweep(input logic [15:0] map);
      logic [3:0] ec;
      held = map;
      for (int j = 0; j < 16; j++) begin
         ec = ~(4'b0001 << (j / 4));
         check("col_drive", btn_key_col, ec);
         @(negedge clk);
      end
      model_sweep(map);
      check("key_state", key_state, m_state);
   endtask

   task automatic check_reset_outputs();
      check("rst_col", btn_key_col, 4'b1110);
      check("rst_state", key_state, 16'h0);
      check("rst_valid", key_valid, 1'b0);
      check("rst_code", key_code, 4'h0);
      check("rst_drop", key_drop, 1'b0);
   endtask

   // Scoreboard monitor: pops one expected code per accepted event.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (key_drop) drops_seen++;
            if (key_valid && exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL spurious_event: key_valid with code %0d, expected none", key_code);
            end else if (key_valid && key_ready) begin
               check("event_code", key_code, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [15:0] m;
      rst = 1'b1; held = '0; key_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;

      // idle sweeps: column walk, nothing reported
      sweep(16'h0); sweep(16'h0);
      check("idle_valid", key_valid, 1'b0);

      // single key 6: latency, accept, no repeat
      sweep(16'h0040); sweep(16'h0040);
      check("k6_state", key_state, 16'h0040);
      check("k6_lat_n1", key_valid, 1'b0);
      @(negedge clk);
      check("k6_lat_n2", key_valid, 1'b1);
      check("k6_code", key_code, 4'd6);
      key_ready = 1'b1;
      @(negedge clk);
      check("k6_accept", key_valid, 1'b0);
      end_sweep(2);
      sweep(16'h0040); sweep(16'h0040);
      sweep(16'h0); sweep(16'h0);

      // bouncing key 5 never settles, then settles once
      for (int i = 0; i < 3; i++) begin sweep(16'h0020); sweep(16'h0); end
      check("bounce_state", key_state, 16'h0);
      sweep(16'h0020); sweep(16'h0020); sweep(16'h0020);
      check("k5_drained", exp_q.size(), 0);
      sweep(16'h0); sweep(16'h0);

      // keys 3 and 12 together, consumer stalled
      key_ready = 1'b0;
      sweep(16'h1008); sweep(16'h1008);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("stall_valid", key_valid, 1'b1);
         check("stall_code", key_code, 4'd3);
      end
      end_sweep(8);
      // release 12 silently, re-press while still pending
      sweep(16'h0008); sweep(16'h0008);
      check("rel12_state", key_state, 16'h0008);
      sweep(16'h1008); sweep(16'h1008);
      check("drop_model", drops_exp, 1);
      check("still_code3", key_code, 4'd3);
      key_ready = 1'b1;
      @(negedge clk);
      check("next_valid", key_valid, 1'b1);
      check("next_code12", key_code, 4'd12);
      @(negedge clk);
      check("drained_valid", key_valid, 1'b0);
      end_sweep(2);
      check("drop_seen", drops_seen, drops_exp);
      sweep(16'h0); sweep(16'h0);

      // reset with an event held and one pending
      key_ready = 1'b0;
      sweep(16'h0280); sweep(16'h0280);
      @(negedge clk);
      check("pre_rst_valid", key_valid, 1'b1);
      check("pre_rst_code", key_code, 4'd7);
      #2 rst = 1'b1; held = '0;
      #1 check_reset_outputs();
      model_reset();
      @(negedge clk);
      rst = 1'b0; key_ready = 1'b1;
      sweep(16'h0); sweep(16'h0); sweep(16'h0);
      check("post_rst_valid", key_valid, 1'b0);

      // random key maps, consumer always ready
      m = '0;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(1, 0) == 1) m = 16'($urandom & $urandom & $urandom);
         sweep(m);
      end
      sweep(16'h0); sweep(16'h0);
      check("final_queue", exp_q.size(), 0);
      check("final_drops", drops_seen, drops_exp);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
